// File: rtl/klein_64_dec.sv
// klein_64_dec: byte-serial KLEIN-64 decryption core.
//
// Takes a 64-bit ciphertext and key as eight byte beats (byte 0 first),
// rolls the key forward to the last round key, runs 12 inverse rounds
// (one per cycle) while rolling the key back, and returns the plaintext
// as eight byte beats.
//
// Ports:
//   ck     in   clock, rising edge
//   rst    in   synchronous active-high reset
//   start  in   one-cycle pulse in IDLE; marks byte 0 of a new block
//   inp    in   [0:7] ciphertext byte, bit 0 = MSB
//   key    in   [0:7] key byte, same beats as inp
//   ready  out  high during the 8 output beats
//   out    out  [0:7] plaintext byte, 8'h00 while ready is low
module klein_64_dec #(
    parameter int NR = 12
) (
    input  logic       ck,
    input  logic       rst,
    input  logic       start,
    input  logic [0:7] inp,
    input  logic [0:7] key,
    output logic       ready,
    output logic [0:7] out
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_EXPAND,
        ST_ROUND,
        ST_OUT
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [63:0] s_q, s_d;
    logic [63:0] k_q, k_d;
    logic        ready_d;
    logic [7:0]  out_d;

    // Nibble S-box; an involution, so it also serves as its own inverse.
    function automatic logic [3:0] sbox(input logic [3:0] x);
        case (x)
            4'h0: sbox = 4'h7;  4'h1: sbox = 4'h4;  4'h2: sbox = 4'hA;  4'h3: sbox = 4'h9;
            4'h4: sbox = 4'h1;  4'h5: sbox = 4'hF;  4'h6: sbox = 4'hB;  4'h7: sbox = 4'h0;
            4'h8: sbox = 4'hC;  4'h9: sbox = 4'h3;  4'hA: sbox = 4'h2;  4'hB: sbox = 4'h6;
            4'hC: sbox = 4'h8;  4'hD: sbox = 4'hE;  4'hE: sbox = 4'hD;  default: sbox = 4'h5;
        endcase
    endfunction

    function automatic logic [7:0] sbox_byte(input logic [7:0] x);
        return {sbox(x[7:4]), sbox(x[3:0])};
    endfunction

    function automatic logic [63:0] sub64(input logic [63:0] v);
        logic [63:0] r;
        for (int n = 0; n < 16; n++) r[4*n +: 4] = sbox(v[4*n +: 4]);
        return r;
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    // GF(2^8) multiply by a 4-bit constant built from xtime terms.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] c);
        logic [7:0] x2, x4, x8;
        x2 = xt(a);
        x4 = xt(x2);
        x8 = xt(x4);
        return ({8{c[0]}} & a) ^ ({8{c[1]}} & x2) ^ ({8{c[2]}} & x4) ^ ({8{c[3]}} & x8);
    endfunction

    // AES InvMixColumns on one 4-byte column, byte 0 in the top bits.
    function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
        logic [7:0] s0, s1, s2, s3;
        s0 = c[31:24]; s1 = c[23:16]; s2 = c[15:8]; s3 = c[7:0];
        return {gmul(s0, 4'hE) ^ gmul(s1, 4'hB) ^ gmul(s2, 4'hD) ^ gmul(s3, 4'h9),
                gmul(s0, 4'h9) ^ gmul(s1, 4'hE) ^ gmul(s2, 4'hB) ^ gmul(s3, 4'hD),
                gmul(s0, 4'hD) ^ gmul(s1, 4'h9) ^ gmul(s2, 4'hE) ^ gmul(s3, 4'hB),
                gmul(s0, 4'hB) ^ gmul(s1, 4'hD) ^ gmul(s2, 4'h9) ^ gmul(s3, 4'hE)};
    endfunction

    function automatic logic [63:0] ks(input logic [63:0] k, input logic [7:0] i);
        logic [31:0] ar, br, ap, bp;
        ar = {k[55:32], k[63:56]};
        br = {k[23:0], k[31:24]};
        ap = br;
        bp = ar ^ br;
        ap[15:8]  = ap[15:8] ^ i;
        bp[23:16] = sbox_byte(bp[23:16]);
        bp[15:8]  = sbox_byte(bp[15:8]);
        return {ap, bp};
    endfunction

    function automatic logic [63:0] inv_ks(input logic [63:0] k, input logic [7:0] i);
        logic [31:0] ap, bp, ar, br;
        ap = k[63:32];
        bp = k[31:0];
        bp[23:16] = sbox_byte(bp[23:16]);
        bp[15:8]  = sbox_byte(bp[15:8]);
        ap[15:8]  = ap[15:8] ^ i;
        br = ap;
        ar = bp ^ ap;
        return {ar[7:0], ar[31:8], br[7:0], br[31:8]};
    endfunction

    function automatic logic [63:0] inv_round(input logic [63:0] s, input logic [63:0] k);
        logic [63:0] t, m;
        t = s ^ k;
        m = {inv_mix_col(t[63:32]), inv_mix_col(t[31:0])};
        return sub64({m[15:0], m[63:16]});
    endfunction

    // Byte j of v, byte 0 being the most significant.
    function automatic logic [7:0] byte_sel(input logic [63:0] v, input logic [2:0] j);
        logic [63:0] sh;
        sh = v << {j, 3'b000};
        return sh[63:56];
    endfunction

    logic [7:0] exp_i, rnd_i;
    assign exp_i = {4'b0000, cnt_q} + 8'd1;
    assign rnd_i = 8'(NR) - {4'b0000, cnt_q};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        k_d     = k_q;
        ready_d = 1'b0;
        out_d   = 8'h00;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    s_d     = {s_q[55:0], inp};
                    k_d     = {k_q[55:0], key};
                    cnt_d   = 4'd1;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                s_d = {s_q[55:0], inp};
                k_d = {k_q[55:0], key};
                if (cnt_q == 4'd7) begin
                    cnt_d   = 4'd0;
                    state_d = ST_EXPAND;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_EXPAND: begin
                k_d = ks(k_q, exp_i);
                if (cnt_q == 4'(NR - 1)) begin
                    cnt_d   = 4'd0;
                    state_d = ST_ROUND;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_ROUND: begin
                s_d = inv_round(s_q, k_q);
                k_d = inv_ks(k_q, rnd_i);
                if (cnt_q == 4'(NR - 1)) begin
                    // Present beat 0 on the same edge that finishes the last round.
                    cnt_d   = 4'd0;
                    state_d = ST_OUT;
                    ready_d = 1'b1;
                    out_d   = byte_sel(s_d ^ k_d, 3'd0);
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_OUT: begin
                if (cnt_q == 4'd7) begin
                    cnt_d   = 4'd0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d   = cnt_q + 4'd1;
                    ready_d = 1'b1;
                    out_d   = byte_sel(s_q ^ k_q, cnt_q[2:0] + 3'd1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge ck) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            s_q     <= 64'd0;
            k_q     <= 64'd0;
            ready   <= 1'b0;
            out     <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            k_q     <= k_d;
            ready   <= ready_d;
            out     <= out_d;
        end
    end

endmodule

// File: tb/tb_klein_64_dec.sv
// tb_klein_64_dec: directed bench for klein_64_dec using the published
// KLEIN-64 vectors, back-to-back blocks, ignored start pulses and resets.
module tb_klein_64_dec;

    logic       ck;
    logic       rst;
    logic       start;
    logic [0:7] inp;
    logic [0:7] key;
    logic       ready;
    logic [0:7] out;

    int n_cmp = 0;
    int n_bad = 0;

    klein_64_dec dut (
        .ck    (ck),
        .rst   (rst),
        .start (start),
        .inp   (inp),
        .key   (key),
        .ready (ready),
        .out   (out)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge ck);
        #1;
    endtask

    // Runs one block starting now (cycle 0). xs_a/xs_b: cycles with extra
    // start pulses (-1 = none). rst_at: cycle in which rst is raised (-1 = none);
    // the block is then abandoned after checking the cleared outputs.
    task automatic run_block(input string name, input logic [63:0] ct, input logic [63:0] kk,
                             input logic [63:0] pt, input int xs_a, input int xs_b,
                             input int rst_at);
        logic [63:0] ctv, kkv, ptv;
        ctv = ct;
        kkv = kk;
        ptv = pt;
        for (int c = 0; c < 40; c++) begin
            if (c >= 32) begin
                check($sformatf("%s ready c%0d", name, c), {63'd0, ready}, 64'd1);
                check($sformatf("%s out c%0d", name, c), {56'd0, out}, {56'd0, ptv[63-8*(c-32) -: 8]});
            end else if (c == 31 || c == 1) begin
                check($sformatf("%s ready c%0d", name, c), {63'd0, ready}, 64'd0);
                check($sformatf("%s out c%0d", name, c), {56'd0, out}, 64'd0);
            end
            if (c < 8) begin
                start = (c == 0);
                inp   = ctv[63-8*c -: 8];
                key   = kkv[63-8*c -: 8];
            end else begin
                start = (c == xs_a) || (c == xs_b);
                inp   = 8'($urandom);
                key   = 8'($urandom);
            end
            rst = (c == rst_at);
            next_cycle();
            if (c == rst_at) begin
                rst   = 1'b0;
                start = 1'b0;
                check($sformatf("%s ready after rst", name), {63'd0, ready}, 64'd0);
                check($sformatf("%s out after rst", name), {56'd0, out}, 64'd0);
                return;
            end
        end
        start = 1'b0;
        check($sformatf("%s ready c40", name), {63'd0, ready}, 64'd0);
        check($sformatf("%s out c40", name), {56'd0, out}, 64'd0);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        inp   = 8'h00;
        key   = 8'h00;
        next_cycle();
        next_cycle();
        check("reset ready", {63'd0, ready}, 64'd0);
        check("reset out", {56'd0, out}, 64'd0);
        rst = 1'b0;
        next_cycle();
        check("idle ready", {63'd0, ready}, 64'd0);

        run_block("v_ffkey", 64'h6456764E8602E154, 64'hFFFFFFFFFFFFFFFF, 64'h0000000000000000, -1, -1, -1);
        next_cycle();
        run_block("v_zerokey", 64'hCDC0B51F14722BBE, 64'h0000000000000000, 64'hFFFFFFFFFFFFFFFF, -1, -1, -1);
        next_cycle();
        run_block("v_key1234", 64'h592356C4997176C8, 64'h1234567890ABCDEF, 64'hFFFFFFFFFFFFFFFF, -1, -1, -1);
        next_cycle();

        // Second block started in cycle 40 of the first: output lands in 72..79.
        run_block("v_pt1234", 64'h629F9D6DFF95800E, 64'h0000000000000000, 64'h1234567890ABCDEF, -1, -1, -1);
        run_block("b2b", 64'h6456764E8602E154, 64'hFFFFFFFFFFFFFFFF, 64'h0000000000000000, -1, -1, -1);
        next_cycle();

        run_block("xstart", 64'hCDC0B51F14722BBE, 64'h0000000000000000, 64'hFFFFFFFFFFFFFFFF, 5, 25, -1);
        next_cycle();

        run_block("rst_c22", 64'h592356C4997176C8, 64'h1234567890ABCDEF, 64'hFFFFFFFFFFFFFFFF, -1, -1, 22);
        run_block("after_rst22", 64'h629F9D6DFF95800E, 64'h0000000000000000, 64'h1234567890ABCDEF, -1, -1, -1);
        next_cycle();

        run_block("rst_c34", 64'h6456764E8602E154, 64'hFFFFFFFFFFFFFFFF, 64'h0000000000000000, -1, -1, 34);
        run_block("after_rst34", 64'h592356C4997176C8, 64'h1234567890ABCDEF, 64'hFFFFFFFFFFFFFFFF, -1, -1, -1);
        next_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/klein_64_dec.md
# klein_64_dec

Byte-serial KLEIN-64 decryption core, the inverse-direction companion to the byte-serial KLEIN-64 encryption core. It accepts a 64-bit ciphertext and 64-bit key as eight byte beats, recovers the last round key internally, and runs 12 inverse rounds. It then returns the 64-bit plaintext as eight byte beats. The start/inp/key/ready/out port set and byte ordering match the encryptor, so one host-side sequencer drives either core.

## Interface
- NR, 12, number of KLEIN rounds. Fixed for KLEIN-64; not meant to be overridden.
- ck  input  1  rising-edge clock, single clock domain
- rst  input  1  reset, synchronous, active-high
- start  input  1  one-cycle pulse, accepted only in IDLE; marks the first byte beat of a new block
- inp  input  [0:7]  ciphertext byte; bit 0 is MSB; byte 0 (ciphertext bits 63..56) comes first
- key  input  [0:7]  key byte, same ordering and beats as inp
- ready  output  1  high during the 8 output beats
- out  output  [0:7]  plaintext byte, byte 0 first; 8'h00 whenever ready is low

## Operation
- States:
  - IDLE→LOAD on start.
  - LOAD (8 beats)→EXPAND.
  - EXPAND (12 cycles)→ROUND.
  - ROUND (12 cycles)→OUT.
  - OUT (8 cycles)→IDLE.
- One 4-bit counter sequences all states. 64-bit state register S and 64-bit key register K.
- LOAD: the start cycle captures byte 0; the following 7 cycles capture bytes 1..7. Bytes shift into S and K, MSB byte first. inp/key are sampled every LOAD cycle regardless of start.
- EXPAND: computes K ← KS(K, i) for i = 1..12, leaving sk13 in K.
- KS(K, i):
  - Split K into a = bytes 0..3 and b = bytes 4..7.
  - Rotate a and b each left by one byte.
  - a' = b; b' = a ^ b.
  - XOR 8-bit i into byte 2 of a'.
  - Apply S-box to each nibble of bytes 1 and 2 of b'.
  - Result is K = a'||b'.
- ROUND: for i = 12 down to 1, S ← Sub(InvRot(InvMix(S ^ K))), then K ← InvKS(K, i).
  - Sub: nibble S-box 7,4,A,9,1,F,B,0,C,3,2,6,8,E,D,5. It is an involution, so the same table serves encryption and decryption.
  - InvRot: rotate the 64-bit state right by 16 bits.
  - InvMix: AES InvMixColumns (GF(2^8), poly 0x11B) applied separately to bytes 0..3 and bytes 4..7.
  - InvKS exactly undoes KS:
    - S-box bytes 1 and 2 of b'.
    - XOR i into byte 2 of a'.
    - b = a'; a = b' ^ a'.
    - Rotate a and b right by one byte.
- After ROUND, K holds sk1.
- OUT: beat j (j = 0..7) drives out = S byte j ^ K byte j; ready = 1.
- start outside IDLE is ignored; a block in flight is never disturbed.
- Back-to-back: start may be asserted in the first IDLE cycle after the last OUT beat.
- rst in any state: the next edge gives IDLE, counter 0, ready 0, out 8'h00. S and K are cleared to 0. Any in-flight block is discarded.

## Timing
- Reset values: ready = 0, out = 8'h00, state IDLE.
- Let cycle 0 be the cycle in which start is high (byte 0 sampled at the end of cycle 0).
  - Bytes 1..7 are sampled in cycles 1..7.
  - EXPAND occupies cycles 8..19.
  - ROUND occupies cycles 20..31.
  - OUT occupies cycles 32..39: ready = 1, out = plaintext byte (cycle − 32).
  - Cycle 40: IDLE, ready = 0.
- Start-to-first-output latency: 32 cycles. Total occupancy: 40 cycles per block.
- out and ready are registered; both change only on ck rising edges.
- One round per cycle. The critical path is the XOR followed by InvMix, InvRot and Sub.

## Test plan
- Key FFFFFFFFFFFFFFFF, ciphertext 6456764E8602E154 → ready high in cycles 32..39, out = 00 ×8.
- Key 0000000000000000, ciphertext CDC0B51F14722BBE → out bytes FF ×8. Check ready is low in cycles 31 and 40.
- Key 1234567890ABCDEF, ciphertext 592356C4997176C8 → out FF ×8.
- Key 0000000000000000, ciphertext 629F9D6DFF95800E → out 12 34 56 78 90 AB CD EF. In the same run, issue a second start in cycle 40 using the first vector; its output must appear in cycles 72..79.
- Extra start pulses in cycles 5 and 25 → ignored; result and timing identical to a clean run.
- rst asserted in cycle 22, then a fresh start → ready and out go to 0 the next cycle; the new block decrypts correctly with standard latency and no residue from the aborted block.
